// File: rtl/pio_strobe_seq.sv
// Trigger-driven strobe sequencer: setup, pulse and hold phases after each rising trig_in edge.
// Optional build macro PIO_STROBE_PENDING_EN queues one extra trigger arriving while busy.
module pio_strobe_seq #(
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trig_in,
    output logic       strobe_out,
    output logic       busy,
    output logic       done_pulse,
    output logic [7:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } state_t;

    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);

    state_t     state;
    logic [7:0] count;
    logic       trig_q;
    logic       rise;
`ifdef PIO_STROBE_PENDING_EN
    logic       pending;
`endif

    assign rise = trig_in & ~trig_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 8'd0;
            trig_q     <= 1'b0;
            strobe_out <= 1'b0;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
            drop_count <= 8'd0;
`ifdef PIO_STROBE_PENDING_EN
            pending    <= 1'b0;
`endif
        end else begin
            trig_q     <= trig_in;
            done_pulse <= 1'b0;

            case (state)
                IDLE: begin
`ifdef PIO_STROBE_PENDING_EN
                    if (rise || pending) begin
                        state   <= SETUP;
                        count   <= SETUP_LOAD;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                    end
`else
                    if (rise) begin
                        state <= SETUP;
                        count <= SETUP_LOAD;
                        busy  <= 1'b1;
                    end
`endif
                end
                SETUP: begin
                    if (count == 8'd0) begin
                        state      <= PULSE;
                        count      <= PULSE_LOAD;
                        strobe_out <= 1'b1;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                PULSE: begin
                    if (count == 8'd0) begin
                        state      <= HOLD;
                        count      <= HOLD_LOAD;
                        strobe_out <= 1'b0;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                HOLD: begin
                    if (count == 8'd0) begin
                        done_pulse <= 1'b1;
`ifdef PIO_STROBE_PENDING_EN
                        // A queued trigger restarts immediately so busy never drops between sequences.
                        if (pending) begin
                            state   <= SETUP;
                            count   <= SETUP_LOAD;
                            pending <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Edges arriving while busy are queued (one deep) or counted as dropped.
            if (state != IDLE && rise) begin
`ifdef PIO_STROBE_PENDING_EN
                if (!pending) begin
                    pending <= 1'b1;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
`else
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_pio_strobe_seq.sv
// Scoreboard bench for pio_strobe_seq: default and minimum-parameter instances share stimulus.
module tb_pio_strobe_seq;

`ifdef PIO_STROBE_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    typedef logic [10:0] exp_t;

    typedef struct {
        bit active;
        bit pending;
        int k0;
        int drops;
    } mstate_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trig_in = 1'b0;
    logic       strobe_def, busy_def, done_def;
    logic [7:0] drop_def;
    logic       strobe_min, busy_min, done_min;
    logic [7:0] drop_min;

    exp_t    q_def[$];
    exp_t    q_min[$];
    mstate_t m_def = '{active: 1'b0, pending: 1'b0, k0: 0, drops: 0};
    mstate_t m_min = '{active: 1'b0, pending: 1'b0, k0: 0, drops: 0};
    bit      model_trig_q = 1'b0;
    int      edge_idx = 0;
    int      vectors = 0;
    int      miscompares = 0;

    always #5 clk = ~clk;

    pio_strobe_seq dut_def (
        .clk        (clk),
        .reset      (reset),
        .trig_in    (trig_in),
        .strobe_out (strobe_def),
        .busy       (busy_def),
        .done_pulse (done_def),
        .drop_count (drop_def)
    );

    pio_strobe_seq #(
        .SETUP_CYCLES (1),
        .PULSE_CYCLES (1),
        .HOLD_CYCLES  (1)
    ) dut_min (
        .clk        (clk),
        .reset      (reset),
        .trig_in    (trig_in),
        .strobe_out (strobe_min),
        .busy       (busy_min),
        .done_pulse (done_min),
        .drop_count (drop_min)
    );

    // Reference: a sequence started at edge k0 is busy for edges k0..k0+T-1, strobes for
    // offsets S..S+P-1 and completes at offset T; edges arriving while one runs are queued/dropped.
    task automatic model_step(input int s, input int p, input int h, input bit rst,
                              input bit rise, input int k, inout mstate_t m, output exp_t e);
        int  t_total;
        bit  done;
        bit  had_pend;
        bit  strobe;
        bit  bsy;
        int  off;
        t_total = s + p + h;
        done = 1'b0;
        if (rst) begin
            m.active  = 1'b0;
            m.pending = 1'b0;
            m.drops   = 0;
        end else if (m.active && k <= m.k0 + t_total) begin
            had_pend = m.pending;
            if (rise) begin
                if (PEND && !m.pending) m.pending = 1'b1;
                else if (m.drops < 255) m.drops = m.drops + 1;
            end
            if (k == m.k0 + t_total) begin
                done = 1'b1;
                if (had_pend) begin
                    m.k0      = k;
                    m.pending = 1'b0;
                end else begin
                    m.active = 1'b0;
                end
            end
        end else if (rise || m.pending) begin
            m.active  = 1'b1;
            m.k0      = k;
            m.pending = 1'b0;
        end
        off    = k - m.k0;
        bsy    = m.active && off >= 0 && off < t_total;
        strobe = m.active && off >= s && off < s + p;
        e = {strobe, bsy, done, 8'(m.drops)};
    endtask

    task automatic applyStimulus(input bit r, input bit t);
        exp_t e;
        bit   rise;
        reset   = r;
        trig_in = t;
        rise = t & ~model_trig_q;
        model_step(2, 4, 3, r, rise, edge_idx, m_def, e);
        q_def.push_back(e);
        model_step(1, 1, 1, r, rise, edge_idx, m_min, e);
        q_min.push_back(e);
        model_trig_q = r ? 1'b0 : t;
        edge_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        exp_t a;
        if (q_def.size() > 0) begin
            e = q_def.pop_front();
            a = {strobe_def, busy_def, done_def, drop_def};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("[TB] FAIL def_outputs t=%0t got strobe=%b busy=%b done=%b drop=%0d expected strobe=%b busy=%b done=%b drop=%0d",
                         $time, a[10], a[9], a[8], a[7:0], e[10], e[9], e[8], e[7:0]);
            end
        end
        if (q_min.size() > 0) begin
            e = q_min.pop_front();
            a = {strobe_min, busy_min, done_min, drop_min};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("[TB] FAIL min_outputs t=%0t got strobe=%b busy=%b done=%b drop=%0d expected strobe=%b busy=%b done=%b drop=%0d",
                         $time, a[10], a[9], a[8], a[7:0], e[10], e[9], e[8], e[7:0]);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            @(negedge clk);
            checkOutput();
        end
    end

    initial begin
        bit t;
        int density;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);

        // Single trigger held high, then released.
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);

        // Two edges three cycles apart.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 25; i++) applyStimulus(1'b0, 1'b0);

        // Reset pulse while the default instance is strobing.
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0);

        // Trigger held high through reset release, then a lone falling edge.
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0);

        // Dense toggling drives the drop counter into saturation.
        for (int i = 0; i < 1400; i++) applyStimulus(1'b0, i[0]);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);

        // Randomised traffic with varying trigger density and rare resets.
        t = 1'b0;
        density = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) density = int'($urandom_range(1, 12));
            if ($urandom_range(0, density - 1) == 0) t = ~t;
            applyStimulus(($urandom_range(0, 199) == 0), t);
        end
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0);

        for (int i = 0; i < 10 && (q_def.size() > 0 || q_min.size() > 0); i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q_def.size() > 0 || q_min.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain got %0d/%0d entries left expected 0/0",
                     q_def.size(), q_min.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
